// File: rtl/control_sequencer_if.sv
// Control port bundle between the Mini SRC hardwired sequencer and its DataPath.
// master = sequencer side, slave = DataPath (or bench) side.
interface control_sequencer_if;
  logic        w_run;
  logic        w_stop;
  logic [31:0] w_ir;
  logic        w_mem_ready;

  logic        s_PC;
  logic        s_Zlow;
  logic        s_Zhigh;
  logic        s_MDR;
  logic        s_Rout;
  logic [1:0]  w_rsel;

  logic        e_MAR;
  logic        e_PC;
  logic        e_MDR;
  logic        e_IR;
  logic        e_Y;
  logic        e_Z;
  logic        e_HI;
  logic        e_LO;
  logic        e_Rin;

  logic        w_IncPC;
  logic        w_read;
  logic        e_alu;
  logic [5:0]  opcode;
  logic        w_busy;
  logic        w_fault;
  logic [15:0] w_icount;

  modport master (
    input  w_run, w_stop, w_ir, w_mem_ready,
    output s_PC, s_Zlow, s_Zhigh, s_MDR, s_Rout, w_rsel,
    output e_MAR, e_PC, e_MDR, e_IR, e_Y, e_Z, e_HI, e_LO, e_Rin,
    output w_IncPC, w_read, e_alu, opcode, w_busy, w_fault, w_icount
  );

  modport slave (
    output w_run, w_stop, w_ir, w_mem_ready,
    input  s_PC, s_Zlow, s_Zhigh, s_MDR, s_Rout, w_rsel,
    input  e_MAR, e_PC, e_MDR, e_IR, e_Y, e_Z, e_HI, e_LO, e_Rin,
    input  w_IncPC, w_read, e_alu, opcode, w_busy, w_fault, w_icount
  );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for the Mini SRC datapath: fetch with memory
// handshake, then register-format ALU execute.
//
// state | meaning
// IDLE  | waiting for w_run
// T0    | PC -> MAR, PC+1 -> Z
// T1    | Zlow -> PC
// T2    | memory read, wait for w_mem_ready
// T3    | MDR -> IR
// E1-E4 | execute steps, content depends on op class
// HALT  | illegal opcode or memory timeout, left only by reset
module control_sequencer #(
  parameter int unsigned MAX_WAIT = 15
) (
  input logic                 w_clock,
  input logic                 w_clear,
  control_sequencer_if.master bus
);

  typedef enum logic [3:0] {IDLE, T0, T1, T2, T3, E1, E2, E3, E4, HALT} state_t;

  state_t      state, state_nxt;
  logic [7:0]  wait_cnt, wait_nxt;
  logic        fault, fault_nxt;
  logic [15:0] icount;
  logic        retire;
  logic        alu;

  logic [4:0] op;
  logic       op_bin, op_un, op_md;
  logic       unused_ir;

  assign op        = bus.w_ir[31:27];
  assign op_bin    = (op <= 5'd3) || ((op >= 5'd7) && (op <= 5'd11));
  assign op_un     = (op == 5'd4) || (op == 5'd12);
  assign op_md     = (op == 5'd5) || (op == 5'd6);
  assign unused_ir = ^bus.w_ir[14:0];

  always_ff @(posedge w_clock or negedge w_clear) begin
    if (!w_clear) begin
      state    <= IDLE;
      wait_cnt <= 8'd0;
      fault    <= 1'b0;
      icount   <= 16'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      fault    <= fault_nxt;
      if (retire) icount <= icount + 16'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    fault_nxt = fault;
    retire    = 1'b0;
    case (state)
      IDLE: if (bus.w_run) state_nxt = T0;
      T0:   state_nxt = T1;
      T1:   state_nxt = T2;
      T2: begin
        if (bus.w_mem_ready) begin
          state_nxt = T3;
          wait_nxt  = 8'd0;
        end else if (wait_cnt == 8'(MAX_WAIT - 1)) begin
          state_nxt = HALT;
          fault_nxt = 1'b1;
          wait_nxt  = 8'd0;
        end else begin
          wait_nxt = wait_cnt + 8'd1;
        end
      end
      T3:   state_nxt = E1;
      E1: begin
        if (!(op_bin || op_un || op_md)) begin
          state_nxt = HALT;
          fault_nxt = 1'b1;
        end else begin
          state_nxt = E2;
        end
      end
      E2:   if (op_un) retire = 1'b1; else state_nxt = E3;
      E3:   if (op_md) state_nxt = E4; else retire = 1'b1;
      E4:   retire = 1'b1;
      HALT: state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
    if (retire) state_nxt = bus.w_stop ? IDLE : T0;
  end

  always_comb begin
    bus.s_PC    = 1'b0;
    bus.s_Zlow  = 1'b0;
    bus.s_Zhigh = 1'b0;
    bus.s_MDR   = 1'b0;
    bus.s_Rout  = 1'b0;
    bus.w_rsel  = 2'd0;
    bus.e_MAR   = 1'b0;
    bus.e_PC    = 1'b0;
    bus.e_MDR   = 1'b0;
    bus.e_IR    = 1'b0;
    bus.e_Y     = 1'b0;
    bus.e_Z     = 1'b0;
    bus.e_HI    = 1'b0;
    bus.e_LO    = 1'b0;
    bus.e_Rin   = 1'b0;
    bus.w_IncPC = 1'b0;
    bus.w_read  = 1'b0;
    alu         = 1'b0;
    case (state)
      T0: begin
        bus.s_PC    = 1'b1;
        bus.e_MAR   = 1'b1;
        bus.w_IncPC = 1'b1;
        bus.e_Z     = 1'b1;
      end
      T1: begin
        bus.s_Zlow = 1'b1;
        bus.e_PC   = 1'b1;
      end
      T2: begin
        bus.w_read = 1'b1;
        bus.e_MDR  = 1'b1;
      end
      T3: begin
        bus.s_MDR = 1'b1;
        bus.e_IR  = 1'b1;
      end
      // illegal opcodes fall through with nothing enabled
      E1: begin
        if (op_bin || op_md) begin
          bus.s_Rout = 1'b1;
          bus.w_rsel = 2'd2;
          bus.e_Y    = 1'b1;
        end else if (op_un) begin
          bus.s_Rout = 1'b1;
          bus.w_rsel = 2'd2;
          alu        = 1'b1;
          bus.e_Z    = 1'b1;
        end
      end
      E2: begin
        if (op_un) begin
          bus.s_Zlow = 1'b1;
          bus.w_rsel = 2'd1;
          bus.e_Rin  = 1'b1;
        end else begin
          bus.s_Rout = 1'b1;
          bus.w_rsel = 2'd3;
          alu        = 1'b1;
          bus.e_Z    = 1'b1;
        end
      end
      E3: begin
        bus.s_Zlow = 1'b1;
        if (op_md) begin
          bus.e_LO = 1'b1;
        end else begin
          bus.w_rsel = 2'd1;
          bus.e_Rin  = 1'b1;
        end
      end
      E4: begin
        bus.s_Zhigh = 1'b1;
        bus.e_HI    = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.e_alu    = alu;
  assign bus.opcode   = alu ? {1'b0, op} : 6'd0;
  assign bus.w_busy   = (state != IDLE) && (state != HALT);
  assign bus.w_fault  = fault;
  assign bus.w_icount = icount;

endmodule
